// File: rtl/vga_sync_pixel_gen_if.sv
// ---------------------------------------------------------------------------
// vga_sync_pixel_gen_if
// Bundles the framebuffer read port and the VGA output signals of
// vga_sync_pixel_gen.
//   master : the timing generator (drives VGA_ADDR and the video outputs)
//   slave  : the surroundings (drive Pix_En, Config_Colors and DATA)
// Signals:
//   Pix_En         pixel beat enable
//   Config_Colors  {background, foreground} colour words
//   DATA           framebuffer read data (1 = foreground)
//   VGA_ADDR       framebuffer read address {v_addr, h_addr}
//   HS, VS         sync outputs
//   ColorOut       pixel colour
//   Blank          high outside the visible area
//   Frame_Start    one-clock pulse with output pixel (0,0)
// ---------------------------------------------------------------------------
interface vga_sync_pixel_gen_if #(
   parameter int COLOR_W  = 8,
   parameter int ADDR_H_W = 8,
   parameter int ADDR_V_W = 7
);
   logic                         Pix_En;
   logic [2*COLOR_W-1:0]         Config_Colors;
   logic                         DATA;
   logic [ADDR_V_W+ADDR_H_W-1:0] VGA_ADDR;
   logic                         HS;
   logic                         VS;
   logic [COLOR_W-1:0]           ColorOut;
   logic                         Blank;
   logic                         Frame_Start;

   modport master (
      input  Pix_En, Config_Colors, DATA,
      output VGA_ADDR, HS, VS, ColorOut, Blank, Frame_Start
   );

   modport slave (
      output Pix_En, Config_Colors, DATA,
      input  VGA_ADDR, HS, VS, ColorOut, Blank, Frame_Start
   );
endinterface

// File: rtl/vga_sync_pixel_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_pixel_gen
// Parametrised VGA timing and pixel generator. Scans the frame with H/V
// counters, issues framebuffer read addresses (stage A), delays the
// per-pixel flags by the RAM read latency and forms the registered video
// outputs from the returned DATA bit (stage B).
// Ports:
//   CLK      system clock, everything on the rising edge
//   Reset_N  asynchronous active-low reset
//   vga      vga_sync_pixel_gen_if.master (Pix_En, Config_Colors, DATA in;
//            VGA_ADDR, HS, VS, ColorOut, Blank, Frame_Start out)
// ---------------------------------------------------------------------------
module vga_sync_pixel_gen #(
   parameter int COLOR_W     = 8,
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 29,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   parameter int SCALE_SHIFT = 2,
   parameter int ADDR_H_W    = 8,
   parameter int ADDR_V_W    = 7,
   parameter int RD_LAT      = 1
) (
   input logic                  CLK,
   input logic                  Reset_N,
   vga_sync_pixel_gen_if.master vga
);
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HC_W     = $clog2(H_TOTAL);
   localparam int VC_W     = $clog2(V_TOTAL);
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
   localparam int ADDR_W   = ADDR_V_W + ADDR_H_W;

   // Flag bit positions inside one delay-line word
   localparam int F_VIS = 0;
   localparam int F_HS  = 1;
   localparam int F_VS  = 2;
   localparam int F_ORG = 3;

   logic [HC_W-1:0]    r_h_count;
   logic [VC_W-1:0]    r_v_count;
   logic [ADDR_W-1:0]  r_addr;
   logic [3:0]         r_dl [RD_LAT];
   logic               r_hs;
   logic               r_vs;
   logic [COLOR_W-1:0] r_color;
   logic               r_blank;
   logic               r_fs;

   logic               w_h_last;
   logic               w_v_last;
   logic               w_visible;
   logic [3:0]         w_flags;
   logic [3:0]         w_tail;
   logic [ADDR_W-1:0]  w_addr;

   assign w_h_last  = (int'(r_h_count) == H_TOTAL - 1);
   assign w_v_last  = (int'(r_v_count) == V_TOTAL - 1);
   assign w_visible = (int'(r_h_count) < H_ACTIVE) && (int'(r_v_count) < V_ACTIVE);

   assign w_flags[F_VIS] = w_visible;
   assign w_flags[F_HS]  = (int'(r_h_count) >= HS_START) && (int'(r_h_count) < HS_END);
   assign w_flags[F_VS]  = (int'(r_v_count) >= VS_START) && (int'(r_v_count) < VS_END);
   assign w_flags[F_ORG] = (r_h_count == '0) && (r_v_count == '0);

   // Decimated coordinates, truncated (or zero-extended) to the address fields
   assign w_addr = w_visible ? {ADDR_V_W'(r_v_count >> SCALE_SHIFT),
                                ADDR_H_W'(r_h_count >> SCALE_SHIFT)} : '0;

   assign w_tail = r_dl[RD_LAT-1];

   // Raster counters: V advances on the beat where H wraps
   always_ff @(posedge CLK or negedge Reset_N) begin
      if (!Reset_N) begin
         r_h_count <= '0;
         r_v_count <= '0;
      end else if (vga.Pix_En) begin
         if (w_h_last) begin
            r_h_count <= '0;
            r_v_count <= w_v_last ? '0 : r_v_count + 1'b1;
         end else begin
            r_h_count <= r_h_count + 1'b1;
         end
      end
   end

   // Stage A: read address plus a flag delay line matching the RAM latency,
   // so the tail flags describe the pixel whose DATA is arriving now.
   always_ff @(posedge CLK or negedge Reset_N) begin
      if (!Reset_N) begin
         r_addr <= '0;
         for (int i = 0; i < RD_LAT; i++) r_dl[i] <= '0;
      end else if (vga.Pix_En) begin
         r_addr  <= w_addr;
         r_dl[0] <= w_flags;
         for (int i = 1; i < RD_LAT; i++) r_dl[i] <= r_dl[i-1];
      end
   end

   // Stage B: registered video outputs. Frame_Start drops on the next clock
   // even without a beat so the pulse is one CLK wide at any beat rate.
   always_ff @(posedge CLK or negedge Reset_N) begin
      if (!Reset_N) begin
         r_hs    <= ~HS_POL;
         r_vs    <= ~VS_POL;
         r_color <= '0;
         r_blank <= 1'b1;
         r_fs    <= 1'b0;
      end else if (vga.Pix_En) begin
         r_hs    <= w_tail[F_HS] ? HS_POL : ~HS_POL;
         r_vs    <= w_tail[F_VS] ? VS_POL : ~VS_POL;
         r_blank <= ~w_tail[F_VIS];
         r_fs    <= w_tail[F_ORG];
         if (w_tail[F_VIS])
            r_color <= vga.DATA ? vga.Config_Colors[COLOR_W-1:0]
                                : vga.Config_Colors[2*COLOR_W-1:COLOR_W];
         else
            r_color <= '0;
      end else begin
         r_fs <= 1'b0;
      end
   end

   assign vga.VGA_ADDR    = r_addr;
   assign vga.HS          = r_hs;
   assign vga.VS          = r_vs;
   assign vga.ColorOut    = r_color;
   assign vga.Blank       = r_blank;
   assign vga.Frame_Start = r_fs;
endmodule

// File: tb/tb_vga_sync_pixel_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_pixel_gen
// Directed bench for vga_sync_pixel_gen on a small raster (24 x 17) with a
// 2-beat framebuffer model holding a checkerboard. A raster model pushes
// the expected output word for every beat into a queue; the word is popped
// when the DUT should present it, RD_LAT beats later.
// ---------------------------------------------------------------------------
module tb_vga_sync_pixel_gen;
   localparam int COLOR_W  = 8;
   localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
   localparam int V_ACTIVE = 12, V_FP = 1, V_SYNC = 2, V_BP = 2;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME    = H_TOTAL * V_TOTAL;
   localparam int SHIFT    = 2;
   localparam int AH_W     = 8;
   localparam int AV_W     = 7;
   localparam int RD_LAT   = 2;
   localparam logic [15:0] COLORS = 16'hE01C;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       blank;
      logic       fs;
      logic [7:0] color;
   } exp_t;

   logic CLK;
   logic Reset_N;

   vga_sync_pixel_gen_if #(.COLOR_W(COLOR_W), .ADDR_H_W(AH_W), .ADDR_V_W(AV_W)) bus ();

   vga_sync_pixel_gen #(
      .COLOR_W(COLOR_W),
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(1'b0), .VS_POL(1'b0),
      .SCALE_SHIFT(SHIFT), .ADDR_H_W(AH_W), .ADDR_V_W(AV_W), .RD_LAT(RD_LAT)
   ) dut (
      .CLK(CLK),
      .Reset_N(Reset_N),
      .vga(bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Checkerboard framebuffer: bit = v_addr[0] ^ h_addr[0]
   function automatic logic pix_bit(input logic [14:0] a);
      return a[8] ^ a[0];
   endfunction

   // Framebuffer model with RD_LAT-1 registered stages (RD_LAT >= 2)
   logic [RD_LAT-2:0] ram_sr;
   always @(posedge CLK) begin
      if (bus.Pix_En) begin
         ram_sr[0] <= pix_bit(bus.VGA_ADDR);
         for (int i = 1; i < RD_LAT - 1; i++) ram_sr[i] <= ram_sr[i-1];
      end
   end
   assign bus.DATA = ram_sr[RD_LAT-2];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          beat  = 0;
   int          m_h, m_v;
   exp_t        q[$];
   exp_t        held;
   logic [14:0] last_addr;
   int          fs_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s beat=%0d pos=(%0d,%0d): observed 0x%0h expected 0x%0h",
                tag, beat, m_h, m_v, obs, exp);
      end
   endtask

   function automatic logic [14:0] model_addr(input int h, input int v);
      logic [6:0] va;
      logic [7:0] ha;
      if (h < H_ACTIVE && v < V_ACTIVE) begin
         va = 7'(v >> SHIFT);
         ha = 8'(h >> SHIFT);
         return {va, ha};
      end
      return '0;
   endfunction

   function automatic exp_t model_out(input int h, input int v);
      exp_t e;
      logic vis;
      vis     = (h < H_ACTIVE) && (v < V_ACTIVE);
      e.hs    = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
      e.vs    = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
      e.blank = !vis;
      e.fs    = (h == 0) && (v == 0);
      e.color = !vis ? 8'h00 : (pix_bit(model_addr(h, v)) ? COLORS[7:0] : COLORS[15:8]);
      return e;
   endfunction

   function automatic exp_t reset_word();
      exp_t e;
      e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b1; e.fs = 1'b0; e.color = 8'h00;
      return e;
   endfunction

   task automatic check_outputs(input string sfx, input exp_t e);
      check({"HS", sfx},          32'(bus.HS),          32'(e.hs));
      check({"VS", sfx},          32'(bus.VS),          32'(e.vs));
      check({"Blank", sfx},       32'(bus.Blank),       32'(e.blank));
      check({"Frame_Start", sfx}, 32'(bus.Frame_Start), 32'(e.fs));
      check({"ColorOut", sfx},    32'(bus.ColorOut),    32'(e.color));
   endtask

   // Asynchronous reset, asserted away from clock edges; ends on a negedge
   // with the model back at (0,0) and the pipeline seeded with reset words.
   task automatic do_reset(input int cycles);
      #2;
      Reset_N = 1'b0;
      #1;
      check_outputs("_rst_async", reset_word());
      check("VGA_ADDR_rst_async", 32'(bus.VGA_ADDR), 32'h0);
      repeat (cycles) begin
         @(negedge CLK);
         check_outputs("_rst", reset_word());
         check("VGA_ADDR_rst", 32'(bus.VGA_ADDR), 32'h0);
      end
      Reset_N   = 1'b1;
      m_h       = 0;
      m_v       = 0;
      q.delete();
      for (int i = 0; i < RD_LAT; i++) q.push_back(reset_word());
      held      = reset_word();
      last_addr = '0;
   endtask

   // One CLK cycle, called just after a negedge
   task automatic tick(input logic en);
      logic [14:0] exp_addr;
      exp_t        e;
      bus.Pix_En = en;
      exp_addr   = model_addr(m_h, m_v);
      if (en) q.push_back(model_out(m_h, m_v));
      @(posedge CLK);
      @(negedge CLK);
      if (en) begin
         beat++;
         check("VGA_ADDR", 32'(bus.VGA_ADDR), 32'(exp_addr));
         if (m_h == 5 && m_v == 9) check("VGA_ADDR_5_9", 32'(bus.VGA_ADDR), 32'h201);
         last_addr = exp_addr;
         if (m_h == H_TOTAL - 1) begin
            m_h = 0;
            m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
         end else begin
            m_h++;
         end
         if (q.size() == 0) begin
            check("scoreboard_underflow", 32'(q.size()), 32'(RD_LAT + 1));
         end else begin
            e    = q.pop_front();
            held = e;
            check_outputs("", e);
         end
      end else begin
         check("VGA_ADDR_hold", 32'(bus.VGA_ADDR), 32'(last_addr));
         e    = held;
         e.fs = 1'b0;
         check_outputs("_hold", e);
      end
      if (bus.Frame_Start) fs_seen++;
   endtask

   initial begin
      Reset_N           = 1'b1;
      bus.Pix_En        = 1'b0;
      bus.Config_Colors = COLORS;
      fs_seen           = 0;

      // Reset held over several edges
      do_reset(4);

      // Full-speed frame: exactly one Frame_Start
      fs_seen = 0;
      for (int i = 0; i < FRAME; i++) tick(1'b1);
      check("frame_start_count", 32'(fs_seen), 32'd1);

      // One beat in four: everything holds between beats
      for (int i = 0; i < 4 * FRAME + 40; i++) tick((i % 4) == 0);

      // Irregular beats
      for (int i = 0; i < 600; i++) tick(1'($urandom_range(0, 1)));

      // Reset mid-line, then restart from (0,0)
      for (int i = 0; i < 7; i++) tick(1'b1);
      do_reset(3);
      fs_seen = 0;
      for (int i = 0; i < 3 * H_TOTAL; i++) tick(1'b1);
      check("frame_start_after_reset", 32'(fs_seen), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/vga_sync_pixel_gen.md
# vga_sync_pixel_gen

Parametrised VGA timing and pixel generator. It is the successor to the fixed 640x480 signal generator and sits between the display framebuffer (a dual-port RAM) and the VGA connector. Every timing field, the sync polarity, the colour width, the address decimation and the framebuffer read latency are parameters. A pixel-clock enable lets it run from the system clock, and the output pipeline is aligned to the RAM read latency. It also supplies blanking and frame-start outputs for the frame-buffer writer.

## Interface
- COLOR_W, 8: bits per colour word
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: horizontal visible, front porch, sync and back porch, in pixels
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 29: vertical fields, in lines
- HS_POL / VS_POL, 0 / 0: active level of HS / VS (0 = active low)
- SCALE_SHIFT, 2: right shift applied to pixel coordinates to form the framebuffer address
- ADDR_H_W / ADDR_V_W, 8 / 7: widths of the horizontal and vertical address fields
- RD_LAT, 1: framebuffer read latency in Pix_En beats, range 1..4
- CLK  in  1  system clock, all logic on its rising edge
- Reset_N  in  1  asynchronous, active-low reset
- Pix_En  in  1  pixel beat; the whole block advances only on CLK edges with Pix_En=1
- Config_Colors  in  2*COLOR_W  [COLOR_W-1:0] foreground (DATA=1), [2*COLOR_W-1:COLOR_W] background (DATA=0)
- DATA  in  1  framebuffer read data, valid RD_LAT beats after the matching VGA_ADDR
- VGA_ADDR  out  ADDR_V_W+ADDR_H_W  framebuffer read address {v_addr, h_addr}
- HS, VS  out  1  sync outputs, registered
- ColorOut  out  COLOR_W  pixel colour, registered
- Blank  out  1  high outside the visible area, aligned with ColorOut
- Frame_Start  out  1  one-CLK pulse aligned with output pixel (0,0)

## Operation
- Totals: H_TOTAL = sum of the H fields (800); V_TOTAL = sum of the V fields (521). The counters are sized with $clog2 of the totals.
- H_Count runs 0..H_TOTAL-1 and wraps to 0. V_Count advances when H_Count wraps, runs 0..V_TOTAL-1 and wraps to 0.
- The region order is active first: visible, front porch, sync, back porch.
- Visible when H_Count < H_ACTIVE and V_Count < V_ACTIVE.
- HS is active when H_ACTIVE+H_FP <= H_Count < H_ACTIVE+H_FP+H_SYNC. VS uses the same rule with the V parameters.
- Stage A (address), on every beat:
  - VGA_ADDR <= visible ? {V_Count>>SCALE_SHIFT, H_Count>>SCALE_SHIFT} : 0.
  - Each field is truncated to ADDR_V_W / ADDR_H_W bits.
  - The visible, HS-active, VS-active and frame-origin flags enter a delay line RD_LAT beats deep.
- Stage B (output), using the delay-line tail:
  - ColorOut <= visible ? (DATA ? fg : bg) : 0
  - Blank <= !visible
  - HS <= active ? HS_POL : !HS_POL; VS likewise with VS_POL
  - Frame_Start <= origin flag
- Frame_Start is cleared on the next CLK edge regardless of Pix_En, so the pulse is exactly one CLK wide.
- Pix_En=0: counters, VGA_ADDR, delay line, HS, VS, ColorOut and Blank all hold.
- Reset (Reset_N low, asynchronous):
  - H_Count, V_Count and VGA_ADDR go to 0.
  - The delay line clears to not-visible / sync-inactive / no-origin.
  - HS = !HS_POL, VS = !VS_POL, ColorOut = 0, Blank = 1, Frame_Start = 0.
  - Asserting reset mid-frame restarts the frame at (0,0) on the first Pix_En beat after release.

## Timing
- Address latency: VGA_ADDR reflects the counter values one beat after those values.
- Output latency: HS, VS, Blank, ColorOut and Frame_Start for counter position (h,v) appear RD_LAT+1 beats after the counters hold (h,v). All outputs stay mutually aligned.
- DATA must be the RAM output for the VGA_ADDR issued RD_LAT beats earlier. Stage B samples it on that beat.
- Defaults with Pix_En=1 every cycle:
  - Line = 800 CLK; HS low for 96 CLK, beginning at line position 656.
  - Frame = 416800 CLK; VS low for 2 lines, starting at line 490.
- Simultaneous H and V wrap on the same beat: V_Count returns to 0 and H_Count returns to 0; the origin flag is set for that beat.

## Test plan
- Reset: hold Reset_N=0 over several edges -> HS=1, VS=1, ColorOut=0, Blank=1, Frame_Start=0, VGA_ADDR=0. Release it -> first Frame_Start arrives RD_LAT+1 beats later.
- Defaults, Pix_En=1 -> HS period 800 CLK with 96 low; VS period 416800 CLK with 1600 CLK low; Frame_Start once per frame; Blank high for 160 CLK per visible line.
- Address: counters at h=5, v=9 -> VGA_ADDR = {7'd2, 8'd1} = 0x201 one beat later; at h=700 -> VGA_ADDR = 0.
- Colour: Config_Colors=0xE01C; DATA=1 in the visible area -> ColorOut=0x1C; DATA=0 -> 0xE0; porch -> 0x00 regardless of DATA.
- Pix_En high one cycle in four -> line = 3200 CLK, all outputs hold between beats, Frame_Start is still 1 CLK wide.
- RD_LAT=2 with a modelled 2-beat RAM holding a checkerboard -> ColorOut edges align exactly with Blank and with the expected pixel boundaries. Apply reset mid-line -> restart at (0,0) with the reset values.
